// File: rtl/riscv_pkg.sv
// Shared definitions for the RISCVerse operand-fetch stage.
// Contents: data width, register index width, instruction field positions,
// the operand bundle handed from operand fetch to execute, and the
// pipeline-register state encoding.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // LSB positions of the register index fields inside the raw instruction
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   typedef struct packed {
      logic [31:0]           instr;
      logic [31:0]           ctrl;
      logic [XLEN-1:0]       rs1_val;
      logic [XLEN-1:0]       rs2_val;
      logic [REG_IDX_W-1:0]  rd;
      logic                  rd_we;
   } operand_bundle_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports and one
// synchronous write port. x0 always reads zero and writes to it are dropped.
// Every entry clears on the asynchronous active-high reset.
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_rd_addr_a/o_rd_data_a  read port A
//   i_rd_addr_b/o_rd_data_b  read port B
//   i_we, i_wr_addr, i_wr_data  write port, takes effect on the rising edge
module reg_file
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] i_rd_addr_a,
   output logic [XLEN-1:0]      o_rd_data_a,
   input  logic [REG_IDX_W-1:0] i_rd_addr_b,
   output logic [XLEN-1:0]      o_rd_data_b,
   input  logic                 i_we,
   input  logic [REG_IDX_W-1:0] i_wr_addr,
   input  logic [XLEN-1:0]      i_wr_data
);

   logic [XLEN-1:0] r_regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wr_addr != '0)) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
      o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
   end

endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: reads rs1/rs2 from the register file (with a
// write-back bypass), tracks in-flight writes in a per-register scoreboard,
// stalls RAW/WAW hazards, and presents operands to execute through a
// one-entry pipeline register.
// Ports:
//   clk, rst                       clock, async active-high reset
//   id_*                           decode handshake and instruction fields
//   wb_valid, wb_rd, wb_data       write-back commit (drives the file write port)
//   ex_*                           registered operands to execute + handshake
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | pipeline register holds nothing, ex_valid = 0
// ST_FULL  | pipeline register holds an instruction, ex_valid = 1
module reg_read_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [31:0]          id_instr,
   input  logic [31:0]          id_ctrl,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic                 id_rd_we,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [31:0]          ex_instr,
   output logic [31:0]          ex_ctrl,
   output logic [XLEN-1:0]      ex_rs1_val,
   output logic [XLEN-1:0]      ex_rs2_val,
   output logic [REG_IDX_W-1:0] ex_rd,
   output logic                 ex_rd_we
);

   stage_state_t    r_state;
   stage_state_t    w_state_next;
   operand_bundle_t r_ex;
   operand_bundle_t w_bundle;
   logic [NREG-1:0] r_sb;
   logic [NREG-1:0] w_sb_next;

   logic [REG_IDX_W-1:0] w_rs1;
   logic [REG_IDX_W-1:0] w_rs2;
   logic [REG_IDX_W-1:0] w_rd;
   logic [XLEN-1:0]      w_rf_rs1;
   logic [XLEN-1:0]      w_rf_rs2;
   logic                 w_wb_hit_rs1;
   logic                 w_wb_hit_rs2;
   logic                 w_wb_hit_rd;
   logic                 w_busy_rs1;
   logic                 w_busy_rs2;
   logic                 w_waw;
   logic                 w_stall;
   logic                 w_accept;

   assign w_rs1 = id_instr[RS1_LSB +: REG_IDX_W];
   assign w_rs2 = id_instr[RS2_LSB +: REG_IDX_W];
   assign w_rd  = id_instr[RD_LSB  +: REG_IDX_W];

   reg_file #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_reg_file (
      .clk         (clk),
      .rst         (rst),
      .i_rd_addr_a (w_rs1),
      .o_rd_data_a (w_rf_rs1),
      .i_rd_addr_b (w_rs2),
      .o_rd_data_b (w_rf_rs2),
      .i_we        (wb_valid),
      .i_wr_addr   (wb_rd),
      .i_wr_data   (wb_data)
   );

   // A write-back landing this cycle resolves the hazard it would otherwise cause.
   assign w_wb_hit_rs1 = wb_valid && (wb_rd == w_rs1);
   assign w_wb_hit_rs2 = wb_valid && (wb_rd == w_rs2);
   assign w_wb_hit_rd  = wb_valid && (wb_rd == w_rd);

   assign w_busy_rs1 = id_rs1_used && r_sb[w_rs1] && !w_wb_hit_rs1;
   assign w_busy_rs2 = id_rs2_used && r_sb[w_rs2] && !w_wb_hit_rs2;
   assign w_waw      = id_rd_we && (w_rd != '0) && r_sb[w_rd] && !w_wb_hit_rd;
   assign w_stall    = w_busy_rs1 || w_busy_rs2 || w_waw;
   assign w_accept   = id_valid && id_ready;

   always_comb begin
      w_bundle         = '0;
      w_bundle.instr   = id_instr;
      w_bundle.ctrl    = id_ctrl;
      w_bundle.rs1_val = (w_wb_hit_rs1 && (w_rs1 != '0)) ? wb_data : w_rf_rs1;
      w_bundle.rs2_val = (w_wb_hit_rs2 && (w_rs2 != '0)) ? wb_data : w_rf_rs2;
      w_bundle.rd      = w_rd;
      w_bundle.rd_we   = id_rd_we && (w_rd != '0);
   end

   // Set is applied after clear so an accept to the same rd wins.
   always_comb begin
      w_sb_next = r_sb;
      if (wb_valid) begin
         w_sb_next[wb_rd] = 1'b0;
      end
      if (w_accept && w_bundle.rd_we) begin
         w_sb_next[w_rd] = 1'b1;
      end
      w_sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex <= '0;
      end else if (w_accept) begin
         r_ex <= w_bundle;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_accept) begin
         w_state_next = ST_FULL;
      end else if ((r_state == ST_FULL) && ex_ready) begin
         w_state_next = ST_EMPTY;
      end
   end

   always_comb begin
      ex_valid = (r_state == ST_FULL);
      id_ready = !rst && !w_stall && ((r_state == ST_EMPTY) || ex_ready);
   end

   assign ex_instr   = r_ex.instr;
   assign ex_ctrl    = r_ex.ctrl;
   assign ex_rs1_val = r_ex.rs1_val;
   assign ex_rs2_val = r_ex.rs2_val;
   assign ex_rd      = r_ex.rd;
   assign ex_rd_we   = r_ex.rd_we;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a behavioural model that is
// compared against the DUT on every falling edge.
module tb_reg_read_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_ready;
   logic [31:0] id_instr, id_ctrl;
   logic        id_rs1_used, id_rs2_used, id_rd_we;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_instr, ex_ctrl, ex_rs1_val, ex_rs2_val;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_read_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_ctrl(id_ctrl),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_we(id_rd_we),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_instr(ex_instr), .ex_ctrl(ex_ctrl),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_valid;
   logic [31:0] m_instr, m_ctrl, m_v1, m_v2;
   logic [4:0]  m_rd;
   bit          m_we;

   always @(negedge clk) begin : model
      logic [4:0]  s1, s2, d;
      logic [31:0] op1, op2;
      bit          hit1, hit2, hitd, stall, exp_ready;
      if (rst) begin
         chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
         chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_valid = 0; m_instr = '0; m_ctrl = '0; m_v1 = '0; m_v2 = '0;
         m_rd = '0; m_we = 0;
      end else begin
         s1 = id_instr[19:15];
         s2 = id_instr[24:20];
         d  = id_instr[11:7];
         hit1 = wb_valid && wb_rd == s1;
         hit2 = wb_valid && wb_rd == s2;
         hitd = wb_valid && wb_rd == d;
         stall = (id_rs1_used && m_pend[s1] && !hit1) ||
                 (id_rs2_used && m_pend[s2] && !hit2) ||
                 (id_rd_we && d != 0 && m_pend[d] && !hitd);
         exp_ready = !stall && (!m_valid || ex_ready);
         chk("id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
         chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
         if (m_valid) begin
            chk("ex_instr", ex_instr, m_instr);
            chk("ex_ctrl", ex_ctrl, m_ctrl);
            chk("ex_rs1_val", ex_rs1_val, m_v1);
            chk("ex_rs2_val", ex_rs2_val, m_v2);
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
            chk("ex_rd_we", {31'b0, ex_rd_we}, {31'b0, m_we});
         end
         op1 = (s1 == 0) ? 32'd0 : (hit1 ? wb_data : m_regs[s1]);
         op2 = (s2 == 0) ? 32'd0 : (hit2 ? wb_data : m_regs[s2]);
         if (wb_valid) begin
            if (wb_rd != 0) m_regs[wb_rd] = wb_data;
            m_pend[wb_rd] = 1'b0;
         end
         if (id_valid && exp_ready) begin
            m_valid = 1; m_instr = id_instr; m_ctrl = id_ctrl;
            m_v1 = op1; m_v2 = op2; m_rd = d;
            m_we = id_rd_we && d != 0;
            if (m_we) m_pend[d] = 1'b1;
         end else if (ex_ready) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd);
      return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input logic [4:0] rd, input bit we);
      id_valid    = 1'b1;
      id_instr    = mk(rs1, rs2, rd);
      id_ctrl     = {rd, rs2, rs1, 17'h1A5A5};
      id_rs1_used = u1;
      id_rs2_used = u2;
      id_rd_we    = we;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = data;
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 0; id_instr = '0; id_ctrl = '0;
      id_rs1_used = 0; id_rs2_used = 0; id_rd_we = 0;
      wb_valid = 0; wb_rd = '0; wb_data = '0;
      ex_ready = 1'b1;
      step(); step();
      chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("reset_ex_rs1", ex_rs1_val, 32'd0);
      chk("reset_id_ready", {31'b0, id_ready}, 32'd0);
      rst = 1'b0;
      step();

      // write-back then read
      wb(5, 32'hDEADBEEF);
      step();
      wb_valid = 0;
      issue(5, 1, 0, 0, 1, 0);
      step();
      id_valid = 0;
      #1;
      chk("wb_read_valid", {31'b0, ex_valid}, 32'd1);
      chk("wb_read_val", ex_rs1_val, 32'hDEADBEEF);

      // bypass
      wb(7, 32'h1234);
      issue(0, 0, 7, 1, 2, 0);
      step();
      wb_valid = 0; id_valid = 0;
      #1;
      chk("bypass_rs2", ex_rs2_val, 32'h1234);

      // RAW stall
      issue(0, 0, 0, 0, 3, 1);
      #1;
      chk("raw_writer_ready", {31'b0, id_ready}, 32'd1);
      step();
      issue(3, 1, 0, 0, 4, 0);
      #1;
      chk("raw_stall_0", {31'b0, id_ready}, 32'd0);
      step();
      chk("raw_stall_1", {31'b0, id_ready}, 32'd0);
      wb(3, 32'hABCD);
      #1;
      chk("raw_release", {31'b0, id_ready}, 32'd1);
      step();
      wb_valid = 0; id_valid = 0;
      #1;
      chk("raw_bypass_val", ex_rs1_val, 32'hABCD);

      // WAW and set-wins
      issue(0, 0, 0, 0, 3, 1);
      step();
      issue(0, 0, 0, 0, 3, 1);
      #1;
      chk("waw_stall", {31'b0, id_ready}, 32'd0);
      step();
      wb(3, 32'h5555);
      #1;
      chk("waw_release", {31'b0, id_ready}, 32'd1);
      step();
      wb_valid = 0;
      issue(3, 1, 0, 0, 0, 0);
      #1;
      chk("set_wins_pending", {31'b0, id_ready}, 32'd0);
      step();
      wb(3, 32'h6666);
      step();
      wb_valid = 0; id_valid = 0;
      #1;
      chk("set_wins_read", ex_rs1_val, 32'h6666);

      // x0 handling
      wb(0, 32'hFFFFFFFF);
      step();
      wb_valid = 0;
      issue(0, 1, 0, 1, 0, 1);
      step();
      #1;
      chk("x0_read", ex_rs1_val, 32'd0);
      chk("x0_rd_we", {31'b0, ex_rd_we}, 32'd0);
      issue(0, 1, 0, 0, 0, 1);
      #1;
      chk("x0_no_stall", {31'b0, id_ready}, 32'd1);
      step();
      id_valid = 0;

      // backpressure, then reset while held
      issue(5, 1, 0, 0, 9, 1);
      step();
      ex_ready = 0;
      issue(1, 1, 0, 0, 10, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_instr", ex_instr, mk(5, 0, 9));
         chk("hold_rs1", ex_rs1_val, 32'hDEADBEEF);
         chk("hold_id_ready", {31'b0, id_ready}, 32'd0);
         step();
      end
      rst = 1'b1;
      #1;
      chk("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("midrst_ex_instr", ex_instr, 32'd0);
      step();
      rst = 1'b0;
      ex_ready = 1;
      issue(9, 1, 0, 0, 0, 0);
      #1;
      chk("sb_cleared", {31'b0, id_ready}, 32'd1);
      step();
      id_valid = 0;
      #1;
      chk("rf_cleared", ex_rs1_val, 32'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         rst      = ($urandom_range(0, 299) == 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         id_valid = ($urandom_range(0, 9) < 7);
         id_instr = $urandom;
         id_instr[19:15] = 5'($urandom_range(0, 7));
         id_instr[24:20] = 5'($urandom_range(0, 7));
         id_instr[11:7]  = 5'($urandom_range(0, 7));
         id_ctrl     = $urandom;
         id_rs1_used = $urandom_range(0, 1);
         id_rs2_used = $urandom_range(0, 1);
         id_rd_we    = $urandom_range(0, 1);
         wb_valid    = ($urandom_range(0, 9) < 4);
         wb_rd       = 5'($urandom_range(0, 7));
         wb_data     = $urandom;
      end
      step();
      rst = 0; id_valid = 0; wb_valid = 0; ex_ready = 1;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-fetch stage of the RISCVerse pipeline: accepts decoded instructions, reads rs1/rs2 from the architectural register file, and hands operands to execute through a one-entry pipeline register. It owns the register file write port driven by write-back and keeps a per-register scoreboard. The scoreboard stalls any instruction that reads or overwrites a register with a write still in flight. It sits between decode and execute and is the read-side counterpart of write-back.

## Interface
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; index width is log2(`NREG`) = 5.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode offers an instruction.
- `id_ready` out 1: stage accepts this cycle.
- `id_instr` in 32: raw instruction; rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- `id_ctrl` in 32: decode control word, passed through untouched.
- `id_rs1_used`, `id_rs2_used` in 1: instruction reads rs1/rs2.
- `id_rd_we` in 1: instruction writes rd.
- `wb_valid` in 1: write-back commits a result this cycle.
- `wb_rd` in 5: destination index.
- `wb_data` in XLEN: result value.
- `ex_valid` out 1: operands valid for execute.
- `ex_ready` in 1: execute accepts.
- `ex_instr`, `ex_ctrl` out 32: registered copies.
- `ex_rs1_val`, `ex_rs2_val` out XLEN: operand values.
- `ex_rd` out 5: destination index.
- `ex_rd_we` out 1: registered `id_rd_we`, forced 0 when rd = 0.

## Operation
- Register file: 32 x XLEN entries; x0 reads 0 always; writes to x0 are dropped.
- Write-back: when `wb_valid`, write `wb_data` to `wb_rd` and clear `sb[wb_rd]`.
- Scoreboard `sb[31:0]`: bit set means a write is in flight. Bit 0 is never set.
- Hazard terms, per source s in {rs1, rs2}:
  - `busy_s = used_s & sb[s] & ~(wb_valid & wb_rd == s)`.
  - `waw = id_rd_we & rd != 0 & sb[rd] & ~(wb_valid & wb_rd == rd)`.
- `stall = busy_rs1 | busy_rs2 | waw`.
- Bypass: if `wb_valid` and `wb_rd == s`, s != 0, the operand takes `wb_data` instead of the file value.
- Pipeline register states:
  - EMPTY (`ex_valid` = 0). FULL (`ex_valid` = 1).
  - `id_ready = ~stall & (~ex_valid | ex_ready)`.
  - Accept (`id_valid & id_ready`): load the register, go to or stay in FULL, and set `sb[rd]` if `ex_rd_we`.
  - FULL & `ex_ready` & no accept: go to EMPTY.
  - FULL & `~ex_ready`: hold all ex outputs stable.
- Same-cycle set and clear of the same rd (write-back clears it, an accepted instruction sets it): set wins, and the bit ends at 1.
- Operands are not re-read while held. Values captured at accept are final, because the scoreboard guarantees no pending write to them.

## Timing
- Reset: `ex_valid` = 0, all ex data outputs 0, `sb` = 0, and every register = 0.
- `id_ready` is combinational from `sb`, `wb_*`, `ex_valid`, `ex_ready`, and the id fields. It is low during reset.
- Latency: accept in cycle N gives `ex_valid` in cycle N+1. Throughput is 1 per cycle with no hazards.
- Register-file write is visible to reads in cycle N+1. The same-cycle read uses the bypass.
- Reset mid-operation: the in-flight instruction is discarded and the scoreboard is cleared. Write-back results arriving after reset are written normally.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`, `REG_IDX_W` = 5.
  - Field slice constants `RS1_LSB`/`RS2_LSB`/`RD_LSB`.
  - Operand-bundle struct (instr, ctrl, rs1_val, rs2_val, rd, rd_we).
- One sub-module, `reg_file`: 2 combinational read ports, 1 synchronous write port, x0 hardwired, async reset. Scoreboard, hazard logic, bypass, and the pipeline register stay in `reg_read_stage`.

## Test plan
- Writeback then read: write x5 = 0xDEADBEEF. Next cycle, an instruction reading rs1 = x5 → `ex_rs1_val` = 0xDEADBEEF one cycle after accept.
- Bypass: `wb_valid`, rd = x7, data 0x1234 in the same cycle an instruction reading rs2 = x7 is accepted → `ex_rs2_val` = 0x1234.
- RAW stall: issue writer rd = x3, then reader rs1 = x3.
  - Reader sees `id_ready` = 0 until write-back of x3.
  - It is accepted in that write-back cycle with the bypassed value.
- WAW and set-wins:
  - A second writer to x3 stalls while x3 is pending.
  - It is accepted in the cycle write-back clears x3, and `sb[3]` remains 1.
- x0: write-back to x0 with 0xFFFFFFFF, then read x0 → 0. An instruction with rd = x0 and we = 1 → `ex_rd_we` = 0, no scoreboard bit set, and no stall on x0.
- Backpressure and reset: hold `ex_ready` = 0 for 3 cycles → ex outputs stable and `id_ready` = 0. Assert `rst` mid-hold → `ex_valid` = 0 and `sb` = 0 immediately.
